// File: rtl/parity_frame_rx.sv
// Even-parity serial frame receiver: start, DATA_W data bits LSB first, parity, stop.
// Optional error counter port err_count is enabled by defining ERR_CNT_EN.
module parity_frame_rx #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              serial_in,
    output logic [DATA_W-1:0] data_out,
    output logic              parity_err,
    output logic              frame_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun,
`ifdef ERR_CNT_EN
    output logic [CNT_W-1:0]  err_count,
`endif
    output logic              busy
);

    localparam int BCNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W - 1);

    if (DATA_W < 2 || CNT_W < 1) begin : g_bad_param
        $error("parity_frame_rx: DATA_W must be >= 2 and CNT_W >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic                par_q, par_d;
    logic                perr_q, perr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                perr_out_q, perr_out_d;
    logic                ferr_out_q, ferr_out_d;
    logic                valid_q, valid_d;
    logic                ovr_q, ovr_d;
    logic                commit;
`ifdef ERR_CNT_EN
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bcnt_q     <= '0;
            par_q      <= 1'b0;
            perr_q     <= 1'b0;
            data_q     <= '0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            valid_q    <= 1'b0;
            ovr_q      <= 1'b0;
`ifdef ERR_CNT_EN
            err_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bcnt_q     <= bcnt_d;
            par_q      <= par_d;
            perr_q     <= perr_d;
            data_q     <= data_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            valid_q    <= valid_d;
            ovr_q      <= ovr_d;
`ifdef ERR_CNT_EN
            err_cnt_q  <= err_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bcnt_d     = bcnt_q;
        par_d      = par_q;
        perr_d     = perr_q;
        data_d     = data_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        valid_d    = valid_q;
        ovr_d      = ovr_q;
        commit     = 1'b0;

        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        if (bit_en) begin
            unique case (state_q)
                IDLE: begin
                    if (!serial_in) begin
                        state_d = DATA;
                        bcnt_d  = '0;
                        par_d   = 1'b0;
                    end
                end
                DATA: begin
                    shift_d = {serial_in, shift_q[DATA_W-1:1]};
                    par_d   = par_q ^ serial_in;
                    bcnt_d  = bcnt_q + 1'b1;
                    if (bcnt_q == LAST_BIT) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    perr_d  = par_q ^ serial_in;
                    state_d = STOP;
                end
                STOP: begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        // A word being accepted this cycle frees the slot for the incoming frame.
        if (commit) begin
            if (!valid_q || out_ready) begin
                data_d     = shift_q;
                perr_out_d = perr_q;
                ferr_out_d = ~serial_in;
                valid_d    = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

`ifdef ERR_CNT_EN
    // Dropped frames count too; saturates rather than wrapping.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (commit && (perr_q || !serial_in) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    assign err_count = err_cnt_q;
`endif

    assign data_out   = data_q;
    assign parity_err = perr_out_q;
    assign frame_err  = ferr_out_q;
    assign out_valid  = valid_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed and randomised checks of parity_frame_rx with hand-computed expectations.
module tb_parity_frame_rx;

    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          bit_en = 1'b0;
    logic          serial_in = 1'b1;
    logic          out_ready = 1'b0;
    logic [DW-1:0] data_out;
    logic          parity_err, frame_err, out_valid, overrun, busy;
`ifdef ERR_CNT_EN
    logic [CW-1:0] err_count;
`endif

    int n_checks = 0;
    int n_fail = 0;

    parity_frame_rx #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bit_en(bit_en),
        .serial_in(serial_in),
        .data_out(data_out),
        .parity_err(parity_err),
        .frame_err(frame_err),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overrun(overrun),
`ifdef ERR_CNT_EN
        .err_count(err_count),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bit time: per-1 idle cycles with a noisy line, then the strobed sample.
    task automatic send_bit(input logic b, input int per);
        for (int i = 0; i < per - 1; i++) begin
            bit_en = 1'b0;
            serial_in = 1'($urandom);
            tick();
        end
        bit_en = 1'b1;
        serial_in = b;
        tick();
        bit_en = 1'b0;
        serial_in = 1'b1;
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic s,
                              input int per, input bit rdy_at_stop);
        send_bit(1'b0, per);
        for (int i = 0; i < DW; i++) send_bit(d[i], per);
        send_bit(p, per);
        if (rdy_at_stop) out_ready = 1'b1;
        send_bit(s, per);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bit_en = 1'b0;
        serial_in = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (data_out !== '0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", data_out); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        n_checks++; if ({parity_err, frame_err} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got=%b%b exp=00", parity_err, frame_err); end
`ifdef ERR_CNT_EN
        n_checks++; if (err_count !== '0) begin n_fail++; $display("FAIL reset_errcnt got=%0d exp=0", err_count); end
`endif
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send_frame(32'h0000_0001, 1'b1, 1'b1, 1, 1'b0);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        n_checks++; if (data_out !== 32'h0000_0001) begin n_fail++; $display("FAIL basic_data got=%h exp=00000001", data_out); end
        n_checks++; if ({parity_err, frame_err} !== 2'b00) begin n_fail++; $display("FAIL basic_flags got=%b%b exp=00", parity_err, frame_err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy got=%b exp=0", busy); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop got=%b exp=0", out_valid); end
        n_checks++; if (data_out !== 32'h0000_0001) begin n_fail++; $display("FAIL basic_data_hold got=%h exp=00000001", data_out); end
    endtask

    task automatic test_parity();
        send_frame(32'hA5A5_A5A5, 1'b1, 1'b1, 1, 1'b0);
        n_checks++; if (data_out !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL par_bad_data got=%h exp=a5a5a5a5", data_out); end
        n_checks++; if (parity_err !== 1'b1) begin n_fail++; $display("FAIL par_bad_perr got=%b exp=1", parity_err); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL par_bad_ferr got=%b exp=0", frame_err); end
`ifdef ERR_CNT_EN
        n_checks++; if (err_count !== 16'd1) begin n_fail++; $display("FAIL par_errcnt got=%0d exp=1", err_count); end
`endif
        tick();
        send_frame(32'hA5A5_A5A5, 1'b0, 1'b1, 1, 1'b0);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL par_ok_valid got=%b exp=1", out_valid); end
        n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL par_ok_perr got=%b exp=0", parity_err); end
        tick();
    endtask

    task automatic test_frame_err();
        send_frame(32'hFFFF_FFFF, 1'b0, 1'b0, 1, 1'b0);
        n_checks++; if (data_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL ferr_data got=%h exp=ffffffff", data_out); end
        n_checks++; if ({parity_err, frame_err} !== 2'b01) begin n_fail++; $display("FAIL ferr_flags got=%b%b exp=01", parity_err, frame_err); end
        send_frame(32'h1234_5678, 1'b1, 1'b1, 1, 1'b0);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ferr_next_valid got=%b exp=1", out_valid); end
        n_checks++; if (data_out !== 32'h1234_5678) begin n_fail++; $display("FAIL ferr_next_data got=%h exp=12345678", data_out); end
        n_checks++; if ({parity_err, frame_err} !== 2'b00) begin n_fail++; $display("FAIL ferr_next_flags got=%b%b exp=00", parity_err, frame_err); end
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        send_frame(32'h0000_0003, 1'b0, 1'b1, 1, 1'b0);
        send_frame(32'h0000_0007, 1'b1, 1'b1, 1, 1'b1);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got=%b exp=1", out_valid); end
        n_checks++; if (data_out !== 32'h0000_0007) begin n_fail++; $display("FAIL b2b_data got=%h exp=00000007", data_out); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_overrun();
        out_ready = 1'b0;
        send_frame(32'h1111_1111, 1'b0, 1'b1, 1, 1'b0);
        send_frame(32'h2222_2222, 1'b0, 1'b0, 1, 1'b0);
        n_checks++; if (data_out !== 32'h1111_1111) begin n_fail++; $display("FAIL ovr_data got=%h exp=11111111", data_out); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid got=%b exp=1", out_valid); end
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ovr_ferr_kept got=%b exp=0", frame_err); end
`ifdef ERR_CNT_EN
        n_checks++; if (err_count !== 16'd3) begin n_fail++; $display("FAIL ovr_errcnt got=%0d exp=3", err_count); end
`endif
        out_ready = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drain got=%b exp=0", out_valid); end
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        send_frame(32'h0000_000F, 1'b0, 1'b1, 1, 1'b0);
        send_bit(1'b0, 1);
        for (int i = 0; i < 10; i++) send_bit(1'b1, 1);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mrst_busy_before got=%b exp=1", busy); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mrst_busy got=%b exp=0", busy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_valid got=%b exp=0", out_valid); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL mrst_overrun got=%b exp=0", overrun); end
        n_checks++; if (data_out !== '0) begin n_fail++; $display("FAIL mrst_data got=%h exp=0", data_out); end
        out_ready = 1'b1;
        send_frame(32'hDEAD_BEEF, 1'b0, 1'b1, 1, 1'b0);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mrst_next_valid got=%b exp=1", out_valid); end
        n_checks++; if (data_out !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL mrst_next_data got=%h exp=deadbeef", data_out); end
        n_checks++; if ({parity_err, frame_err} !== 2'b00) begin n_fail++; $display("FAIL mrst_next_flags got=%b%b exp=00", parity_err, frame_err); end
        tick();
    endtask

    task automatic test_random();
        logic [DW-1:0] d;
        logic          bad;
        int            n_bad;
        n_bad = 0;
        do_reset();
        out_ready = 1'b1;
        for (int f = 0; f < 100; f++) begin
            d = DW'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            if (bad) n_bad++;
            repeat ($urandom_range(0, 3)) send_bit(1'b1, 4);
            send_frame(d, (^d) ^ bad, 1'b1, 4, 1'b0);
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rnd_valid f=%0d got=%b exp=1", f, out_valid); end
            n_checks++; if (data_out !== d) begin n_fail++; $display("FAIL rnd_data f=%0d got=%h exp=%h", f, data_out, d); end
            n_checks++; if ({parity_err, frame_err} !== {bad, 1'b0}) begin n_fail++; $display("FAIL rnd_flags f=%0d got=%b%b exp=%b0", f, parity_err, frame_err, bad); end
        end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rnd_overrun got=%b exp=0", overrun); end
`ifdef ERR_CNT_EN
        n_checks++; if (err_count !== CW'(n_bad)) begin n_fail++; $display("FAIL rnd_errcnt got=%0d exp=%0d", err_count, n_bad); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_frame_err();
        test_back_to_back();
        test_overrun();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
